// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Multi-source interrupt controller in front of cp0. Edge-detects
//               the irq_src lines, latches pending interrupts, applies a
//               software mask, arbitrates, and sequences one interrupt at a
//               time through REQ (wait taken) and SERVICE (wait eret).
//               Optional macro IRQ_CTRL_ROUND_ROBIN_EN selects round-robin
//               arbitration; the default is fixed priority (lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
    parameter int               N_SRC    = 8,
    parameter int               ID_W     = 3,
    parameter logic [N_SRC-1:0] MASK_RST = {N_SRC{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             ir_en,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             taken,
    input  logic             eret,
    output logic             ir_req,
    output logic [ID_W-1:0]  cause_id,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask,
    output logic             busy
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_req     = 2'd1;
    localparam logic [1:0] c_service = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N_SRC-1:0] src_q, src_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [ID_W-1:0]  cause_id_q, cause_id_d;

    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_eligible;
    logic [ID_W-1:0]  w_grant_id;
    logic             w_grant_vld;
    logic             w_start;
    logic             w_accept;

    assign w_eligible  = pending_q & ~mask_q;
    assign w_grant_vld = |w_eligible;
    // A grant is only launched from IDLE; once in REQ the request is committed
    assign w_start     = (state_q == c_idle) && ir_en && w_grant_vld;
    assign w_accept    = (state_q == c_req) && taken;

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0] w_rot;
    logic [ID_W-1:0]  w_rot_idx;
    logic [ID_W:0]    w_sum;

    // Round-robin: rotate eligible so rr_ptr sits at bit 0, pick lowest, rotate back
    always_comb begin
        w_rot     = N_SRC'({w_eligible, w_eligible} >> rr_ptr_q);
        w_rot_idx = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_rot_idx = ID_W'(k);
            end
        end
        w_sum = {1'b0, rr_ptr_q} + {1'b0, w_rot_idx};
        if (w_sum >= (ID_W+1)'(N_SRC)) begin
            w_sum = w_sum - (ID_W+1)'(N_SRC);
        end
        w_grant_id = w_sum[ID_W-1:0];
    end

    // Pointer moves just past the source that was accepted
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_accept) begin
            rr_ptr_d = (cause_id_q == ID_W'(N_SRC - 1)) ? '0 : cause_id_q + ID_W'(1);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority: scan downwards so the lowest eligible index is kept
    always_comb begin
        w_grant_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_grant_id = ID_W'(i);
            end
        end
    end
`endif

    // Datapath next values: edge detect, pending set/clear (set wins), mask, cause
    always_comb begin
        src_d  = irq_src;
        w_rise = irq_src & ~src_q;
        w_clr  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_accept && (cause_id_q == ID_W'(i))) begin
                w_clr[i] = 1'b1;
            end
        end
        pending_d  = (pending_q & ~w_clr) | w_rise;
        mask_d     = mask_we ? mask_wdata : mask_q;
        cause_id_d = w_start ? w_grant_id : cause_id_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q      <= '0;
            pending_q  <= '0;
            mask_q     <= MASK_RST;
            cause_id_q <= '0;
        end else begin
            src_q      <= src_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            cause_id_q <= cause_id_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; stray taken/eret outside their state are ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle:    if (w_start) state_d = c_req;
            c_req:     if (taken)   state_d = c_service;
            c_service: if (eret)    state_d = c_idle;
            default:                state_d = c_idle;
        endcase
    end

    // FSM outputs decoded from the registered state
    always_comb begin
        ir_req = (state_q == c_req);
        busy   = (state_q != c_idle);
    end

    assign cause_id = cause_id_q;
    assign pending  = pending_q;
    assign mask     = mask_q;

endmodule
`default_nettype wire
